// File: rtl/touch_coord_fetch.sv
// Polls a capacitive touch controller over a byte-wide I2C master and reports clamped {x,y} coordinates.
// Latency: one poll is POLL_DIV idle cycles plus up to six byte transactions; coord_valid follows the clear write by 2 cycles.
// Backpressure: one transaction outstanding at a time; waits on i2c_done, aborts after TIMEOUT cycles or on NACK.
module touch_coord_fetch #(
  parameter int INIT_WAIT = 2_500_000,
  parameter int POLL_DIV  = 500_000,
  parameter int TIMEOUT   = 100_000,
  parameter int H_ACT     = 1024,
  parameter int V_ACT     = 600
) (
  input  logic        clk,
  input  logic        reset,
  output logic        i2c_exec,
  output logic        i2c_rh_wl,
  output logic [15:0] i2c_addr,
  output logic [7:0]  i2c_data_w,
  input  logic [7:0]  i2c_data_r,
  input  logic        i2c_done,
  input  logic        i2c_ack,
  output logic [31:0] data_out,
  output logic        touch_pressed,
  output logic        coord_valid,
  output logic [7:0]  err_cnt
);

  typedef enum logic [3:0] {
    INIT, IDLE, RD_STAT, RD_XL, RD_XH, RD_YL, RD_YH, CLR_STAT, UPDATE
  } state_t;

  localparam logic [15:0] ADDR_STAT = 16'h814E;
  localparam logic [15:0] ADDR_XL   = 16'h8150;
  localparam logic [15:0] ADDR_XH   = 16'h8151;
  localparam logic [15:0] ADDR_YL   = 16'h8152;
  localparam logic [15:0] ADDR_YH   = 16'h8153;

  localparam logic [15:0] X_MAX = 16'(H_ACT - 1);
  localparam logic [15:0] Y_MAX = 16'(V_ACT - 1);

  localparam logic [31:0] INIT_LAST = 32'(INIT_WAIT - 1);
  localparam logic [31:0] POLL_LAST = 32'(POLL_DIV - 1);
  localparam logic [31:0] TMO_LAST  = 32'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [31:0] timer_q, timer_d;
  logic        issued_q, issued_d;     // exec already pulsed in the current transaction state
  logic [7:0]  xl_q, xl_d;
  logic [7:0]  xh_q, xh_d;
  logic [7:0]  yl_q, yl_d;
  logic [31:0] pend_q, pend_d;         // coordinate waiting for the status clear to finish
  logic        pend_press_q, pend_press_d;
  logic [31:0] data_out_q, data_out_d;
  logic        pressed_q, pressed_d;
  logic        coord_valid_q, coord_valid_d;
  logic [7:0]  err_q, err_d;

  logic        in_xact;
  logic        abort;
  logic [15:0] x_raw, y_raw, x_clamp, y_clamp;

  // Transaction states share the exec/wait/timeout handling.
  always_comb begin
    in_xact = (state_q == RD_STAT) || (state_q == RD_XL) || (state_q == RD_XH) ||
              (state_q == RD_YL)   || (state_q == RD_YH) || (state_q == CLR_STAT);
  end

  // Bus request fields decode straight from the state so they stay put for the whole transaction.
  always_comb begin
    i2c_exec   = in_xact && !issued_q;
    i2c_rh_wl  = (state_q != CLR_STAT);
    i2c_data_w = 8'h00;                // the only write ever issued clears the status register
    unique case (state_q)
      RD_STAT, CLR_STAT: i2c_addr = ADDR_STAT;
      RD_XL:             i2c_addr = ADDR_XL;
      RD_XH:             i2c_addr = ADDR_XH;
      RD_YL:             i2c_addr = ADDR_YL;
      RD_YH:             i2c_addr = ADDR_YH;
      default:           i2c_addr = 16'h0000;
    endcase
  end

  // Assemble and clamp the coordinate; YH is taken directly from the bus in its done cycle.
  always_comb begin
    x_raw   = {xh_q, xl_q};
    y_raw   = {i2c_data_r, yl_q};
    x_clamp = (x_raw > X_MAX) ? X_MAX : x_raw;
    y_clamp = (y_raw > Y_MAX) ? Y_MAX : y_raw;
  end

  // Next-state and datapath control for the poll sequence.
  always_comb begin
    state_d       = state_q;
    timer_d       = timer_q;
    issued_d      = issued_q;
    xl_d          = xl_q;
    xh_d          = xh_q;
    yl_d          = yl_q;
    pend_d        = pend_q;
    pend_press_d  = pend_press_q;
    data_out_d    = data_out_q;
    pressed_d     = pressed_q;
    coord_valid_d = 1'b0;
    err_d         = err_q;
    abort         = 1'b0;

    unique case (state_q)
      INIT: begin
        if (timer_q == INIT_LAST) begin
          state_d = IDLE;
          timer_d = '0;
        end else begin
          timer_d = timer_q + 32'd1;
        end
      end

      IDLE: begin
        if (timer_q == POLL_LAST) begin
          state_d  = RD_STAT;
          timer_d  = '0;
          issued_d = 1'b0;
        end else begin
          timer_d = timer_q + 32'd1;
        end
      end

      RD_STAT, RD_XL, RD_XH, RD_YL, RD_YH, CLR_STAT: begin
        if (!issued_q) begin
          // exec cycle: any done seen now belongs to nothing we issued
          issued_d = 1'b1;
          timer_d  = '0;
        end else if (i2c_done) begin
          if (i2c_ack) begin
            abort = 1'b1;
          end else begin
            issued_d = 1'b0;
            unique case (state_q)
              RD_STAT: begin
                if (!i2c_data_r[7]) begin
                  state_d = IDLE;
                  timer_d = '0;
                end else if (i2c_data_r[3:0] == 4'd0) begin
                  pend_d       = 32'h0;
                  pend_press_d = 1'b0;
                  state_d      = CLR_STAT;
                end else if (i2c_data_r[3:0] <= 4'd5) begin
                  state_d = RD_XL;
                end else begin
                  abort = 1'b1;
                end
              end
              RD_XL: begin
                xl_d    = i2c_data_r;
                state_d = RD_XH;
              end
              RD_XH: begin
                xh_d    = i2c_data_r;
                state_d = RD_YL;
              end
              RD_YL: begin
                yl_d    = i2c_data_r;
                state_d = RD_YH;
              end
              RD_YH: begin
                pend_d       = {x_clamp, y_clamp};
                pend_press_d = 1'b1;
                state_d      = CLR_STAT;
              end
              default: begin
                state_d = UPDATE;
              end
            endcase
          end
        end else if (timer_q >= TMO_LAST) begin
          abort = 1'b1;
        end else begin
          timer_d = timer_q + 32'd1;
        end
      end

      UPDATE: begin
        data_out_d    = pend_q;
        pressed_d     = pend_press_q;
        coord_valid_d = 1'b1;
        state_d       = IDLE;
        timer_d       = '0;
      end

      default: begin
        state_d = INIT;
        timer_d = '0;
      end
    endcase

    // Aborted polls keep the last reported point and only bump the error count.
    if (abort) begin
      state_d  = IDLE;
      timer_d  = '0;
      issued_d = 1'b0;
      if (err_q != 8'hFF) begin
        err_d = err_q + 8'd1;
      end
    end
  end

  // State and output registers; reset drops everything and restarts the power-up wait.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= INIT;
      timer_q       <= '0;
      issued_q      <= 1'b0;
      xl_q          <= '0;
      xh_q          <= '0;
      yl_q          <= '0;
      pend_q        <= '0;
      pend_press_q  <= 1'b0;
      data_out_q    <= '0;
      pressed_q     <= 1'b0;
      coord_valid_q <= 1'b0;
      err_q         <= '0;
    end else begin
      state_q       <= state_d;
      timer_q       <= timer_d;
      issued_q      <= issued_d;
      xl_q          <= xl_d;
      xh_q          <= xh_d;
      yl_q          <= yl_d;
      pend_q        <= pend_d;
      pend_press_q  <= pend_press_d;
      data_out_q    <= data_out_d;
      pressed_q     <= pressed_d;
      coord_valid_q <= coord_valid_d;
      err_q         <= err_d;
    end
  end

  assign data_out      = data_out_q;
  assign touch_pressed = pressed_q;
  assign coord_valid   = coord_valid_q;
  assign err_cnt       = err_q;

endmodule

// File: doc/touch_coord_fetch.md
TOUCH_COORD_FETCH -- requirements
Module: touch_coord_fetch

Interface
REQ-001 Parameters SHALL be: INIT_WAIT, default 2_500_000, post-reset quiet cycles before first poll; POLL_DIV, default 500_000, cycles from end of one poll to start of next; TIMEOUT, default 100_000, max cycles waiting for i2c_done; H_ACT, default 1024, panel width; V_ACT, default 600, panel height.
REQ-002 Port clk, input, 1, the single clock; all state SHALL update on its rising edge.
REQ-003 Port reset, input, 1, asynchronous active-low reset.
REQ-004 Port i2c_exec, output, 1, one-cycle pulse that starts one byte transaction.
REQ-005 Port i2c_rh_wl, output, 1; 1 = read, 0 = write; held stable from i2c_exec until i2c_done.
REQ-006 Port i2c_addr, output, 16, register address; held stable from i2c_exec until i2c_done.
REQ-007 Port i2c_data_w, output, 8, write byte; held stable from i2c_exec until i2c_done.
REQ-008 Port i2c_data_r, input, 8, read byte; valid only in the cycle i2c_done=1.
REQ-009 Port i2c_done, input, 1, one-cycle transaction-complete pulse.
REQ-010 Port i2c_ack, input, 1, NACK flag (1 = error); sampled with i2c_done.
REQ-011 Port data_out, output, 32, {x[15:0], y[15:0]} in plain binary, for the touch-area decoder.
REQ-012 Port touch_pressed, output, 1, 1 while a point is reported.
REQ-013 Port coord_valid, output, 1, one-cycle pulse whenever data_out is updated (press or release).
REQ-014 Port err_cnt, output, 8, count of aborted polls; saturates at 255.

Function
REQ-015 FSM states SHALL be: INIT, IDLE, RD_STAT, RD_XL, RD_XH, RD_YL, RD_YH, CLR_STAT, UPDATE.
REQ-016 INIT: count INIT_WAIT cycles, then go to IDLE with the poll timer cleared.
REQ-017 IDLE: count POLL_DIV cycles, then go to RD_STAT.
REQ-018 Each transaction state SHALL pulse i2c_exec in its first cycle, then wait for i2c_done; an i2c_done arriving in the exec cycle SHALL be ignored.
REQ-019 Registers read, in order:
  - RD_STAT: 0x814E
  - RD_XL: 0x8150
  - RD_XH: 0x8151
  - RD_YL: 0x8152
  - RD_YH: 0x8153
REQ-020 Status byte handling at RD_STAT done:
  - bit7=0: return to IDLE; data_out unchanged; no coord_valid pulse.
  - bit7=1 and bits[3:0]=0: release; go to CLR_STAT with pending coordinate 32'h0.
  - bit7=1 and bits[3:0] in 1..5: go to RD_XL.
  - bit7=1 and bits[3:0]>5: treat as error (REQ-024).
REQ-021 x = {XH,XL}, y = {YH,YL}. Before use, x SHALL be clamped to H_ACT-1 and y clamped to V_ACT-1.
REQ-022 CLR_STAT SHALL write 8'h00 to 0x814E, then go to UPDATE.
REQ-023 UPDATE (one cycle):
  - load data_out with the pending coordinate;
  - set touch_pressed = (pending != release);
  - pulse coord_valid;
  - go to IDLE.
REQ-024 Error path, taken on i2c_ack=1 at any i2c_done, or i2c_done absent after TIMEOUT cycles:
  - abort to IDLE;
  - increment err_cnt (saturating at 255);
  - leave data_out and touch_pressed unchanged;
  - issue no coord_valid pulse.
REQ-025 A release SHALL always drive data_out to 32'h0, which lies outside every decoder button region.
REQ-026 Poll period = POLL_DIV + transaction time. The poll timer SHALL restart on every entry to IDLE.
REQ-027 At most one transaction SHALL be outstanding at any time.

Reset
REQ-028 On reset=0, all outputs SHALL clear asynchronously within the same cycle:
  - data_out = 0
  - touch_pressed = 0
  - coord_valid = 0
  - i2c_exec = 0
  - i2c_rh_wl = 1
  - i2c_addr = 0
  - i2c_data_w = 0
  - err_cnt = 0
REQ-029 On reset=0 the FSM SHALL enter INIT and all timers SHALL clear.
REQ-030 Reset asserted mid-transaction SHALL abandon the transaction without a further i2c_exec. After release, INIT_WAIT SHALL elapse again before the next poll.

Verification
REQ-031 Test parameters: INIT_WAIT=20, POLL_DIV=50, TIMEOUT=40. The slave model returns i2c_done 10 cycles after each i2c_exec.
REQ-032 Press: status 0x81, XL=0xF4, XH=0x01, YL=0xC8, YH=0x00 -> six transactions in order (5 reads, then write 0x00 to 0x814E); data_out=0x01F4_00C8; touch_pressed=1; one coord_valid pulse.
REQ-033 Release: following press, status 0x80 -> clear write; data_out=0; touch_pressed=0; coord_valid pulses once.
REQ-034 Not ready: status 0x00 -> no further transactions; data_out unchanged; next RD_STAT starts 50 cycles after return to IDLE.
REQ-035 Clamp: X=0x0500, Y=0x03E8 -> data_out=0x03FF_0257.
REQ-036 Errors:
  - NACK on RD_YL -> err_cnt=1, data_out holds previous value;
  - no i2c_done -> abort after 40 cycles, err_cnt increments.
REQ-037 Reset during RD_XH -> outputs zero immediately; first i2c_exec after reset release occurs no earlier than 20+50 cycles.
